aes_round_tail: RTL and testbench

- Downstream neighbour of the byte-substitution stage in the iterative AES-128 encrypt datapath.
- Takes the substituted state and applies ShiftRows, then MixColumns (skipped on the final round), then AddRoundKey.
- Keeps its own round counter, so the key scheduler and top-level controller are told the round number and when the last round completes.
- 2-cycle pipeline; accepts one state per cycle.

---
 rtl/aes_round_tail.sv | 136 +++++++++++++
 tb/tb_aes_round_tail.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_tail.sv
// AES-128 round tail: ShiftRows, MixColumns (bypassed on the final round) and AddRoundKey, 2-cycle pipeline.
// Optional sticky restart/re-arm error output round_err is built when AES_ROUND_TAIL_ERR_EN is defined.
module aes_round_tail #(
  parameter int DATA_LEN   = 128,
  parameter int NUM_ROUNDS = 10,
  parameter int RND_W      = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                valid_in,
  input  logic [DATA_LEN-1:0] data_in,
  input  logic [DATA_LEN-1:0] round_key,
  output logic                valid_out,
  output logic [DATA_LEN-1:0] data_out,
  output logic [RND_W-1:0]    round_out,
  output logic                last_out
`ifdef AES_ROUND_TAIL_ERR_EN
  ,
  output logic                round_err
`endif
);

  localparam logic [RND_W-1:0] LAST_RND = RND_W'(NUM_ROUNDS);
  localparam logic [RND_W-1:0] ONE_RND  = RND_W'(1);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0]          w_sr [16];
  logic [DATA_LEN-1:0] w_sr_flat;
  logic [DATA_LEN-1:0] w_mc_flat;
  logic [RND_W-1:0]    w_tag;

  logic [RND_W-1:0]    r_rnd;
  logic                r_s1_valid;
  logic [DATA_LEN-1:0] r_s1_data;
  logic [DATA_LEN-1:0] r_s1_key;
  logic [RND_W-1:0]    r_s1_rnd;
  logic                r_valid_out;
  logic [DATA_LEN-1:0] r_data_out;
  logic [RND_W-1:0]    r_round_out;
  logic                r_last_out;

  // Byte gi is state element s[gi%4][gi/4]; each generate slice produces one output byte.
  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    localparam int R   = gi % 4;
    localparam int C   = gi / 4;
    localparam int SRC = 4 * ((C + R) % 4) + R;
    logic [7:0] w_a0, w_a1, w_a2, w_a3;

    assign w_sr[gi] = data_in[DATA_LEN-1-8*SRC -: 8];
    assign w_a0 = w_sr[4*C + R];
    assign w_a1 = w_sr[4*C + (R + 1) % 4];
    assign w_a2 = w_sr[4*C + (R + 2) % 4];
    assign w_a3 = w_sr[4*C + (R + 3) % 4];

    assign w_sr_flat[DATA_LEN-1-8*gi -: 8] = w_sr[gi];
    assign w_mc_flat[DATA_LEN-1-8*gi -: 8] = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
  end

  // A start in the same cycle as a beat tags that beat as round 1.
  assign w_tag = start ? ONE_RND : r_rnd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rnd       <= ONE_RND;
      r_s1_valid  <= 1'b0;
      r_s1_data   <= '0;
      r_s1_key    <= '0;
      r_s1_rnd    <= '0;
      r_valid_out <= 1'b0;
      r_data_out  <= '0;
      r_round_out <= '0;
      r_last_out  <= 1'b0;
    end else begin
      if (valid_in) begin
        r_rnd <= (w_tag == LAST_RND) ? ONE_RND : w_tag + ONE_RND;
      end else if (start) begin
        r_rnd <= ONE_RND;
      end

      r_s1_valid <= valid_in;
      if (valid_in) begin
        r_s1_data <= (w_tag == LAST_RND) ? w_sr_flat : w_mc_flat;
        r_s1_key  <= round_key;
        r_s1_rnd  <= w_tag;
      end

      r_valid_out <= r_s1_valid;
      r_last_out  <= r_s1_valid && (r_s1_rnd == LAST_RND);
      if (r_s1_valid) begin
        r_data_out  <= r_s1_data ^ r_s1_key;
        r_round_out <= r_s1_rnd;
      end
    end
  end

  assign valid_out = r_valid_out;
  assign data_out  = r_data_out;
  assign round_out = r_round_out;
  assign last_out  = r_last_out;

`ifdef AES_ROUND_TAIL_ERR_EN
  logic r_round_err;
  logic r_wrapped;
  logic w_err_set;

  // r_wrapped remembers that a final-round beat went in and no start has re-armed the counter since.
  assign w_err_set = (start && (r_s1_valid || r_valid_out)) ||
                     (valid_in && !start && r_wrapped && (r_rnd == ONE_RND));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_round_err <= 1'b0;
      r_wrapped   <= 1'b0;
    end else begin
      if (w_err_set) begin
        r_round_err <= 1'b1;
      end else if (start) begin
        r_round_err <= 1'b0;
      end

      if (valid_in && (w_tag == LAST_RND)) begin
        r_wrapped <= 1'b1;
      end else if (start) begin
        r_wrapped <= 1'b0;
      end
    end
  end

  assign round_err = r_round_err;
`endif

endmodule

// File: tb/tb_aes_round_tail.sv
// Directed bench for aes_round_tail: reference-model scoreboard plus FIPS-197 round vectors.
// Exercises round_err as well when AES_ROUND_TAIL_ERR_EN is defined.
module tb_aes_round_tail;

  localparam logic [127:0] FIPS_D1 = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] FIPS_K1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_O1 = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] FIN_D   = 128'he9098972cb31075f3d327d94af2e2cb5;
  localparam logic [127:0] FIN_K   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIN_O   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] MC_D    = 128'hdb000000_00130000_00005300_00000045;
  localparam logic [127:0] MC_O    = 128'h8e4da1bc_00000000_00000000_00000000;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         valid_in = 1'b0;
  logic [127:0] data_in = '0;
  logic [127:0] round_key = '0;
  logic         valid_out;
  logic [127:0] data_out;
  logic [3:0]   round_out;
  logic         last_out;
`ifdef AES_ROUND_TAIL_ERR_EN
  logic         round_err;
`endif

  int tests = 0;
  int fails = 0;
  int mrnd = 1;
  logic [1:0] vpipe = 2'b00;

  typedef struct packed {
    logic [127:0] data;
    logic [3:0]   rnd;
    logic         last;
  } exp_t;
  exp_t sb[$];

  aes_round_tail dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .round_key (round_key),
    .valid_out (valid_out),
    .data_out  (data_out),
    .round_out (round_out),
    .last_out  (last_out)
`ifdef AES_ROUND_TAIL_ERR_EN
    ,
    .round_err (round_err)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_round(input logic [127:0] d, input logic [127:0] k, input int tag);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   m [16];
    logic [7:0]   coef [4];
    logic [127:0] res;
    coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    for (int i = 0; i < 16; i++) s[i] = d[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[4*c+r] = s[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        m[4*c+r] = 8'h00;
        for (int j = 0; j < 4; j++) m[4*c+r] = m[4*c+r] ^ gmul(coef[(j-r+4)%4], t[4*c+j]);
      end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = ((tag == 10) ? t[i] : m[i]) ^ k[127-8*i -: 8];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, update the reference model, then check the outputs after the edge.
  task automatic do_cycle(input logic s, input logic v, input logic [127:0] d, input logic [127:0] k,
                          input logic ov, input logic [127:0] ov_data);
    exp_t e;
    int   tag;
    start = s; valid_in = v; data_in = d; round_key = k;
    if (v) begin
      tag = s ? 1 : mrnd;
      e.data = ov ? ov_data : ref_round(d, k, tag);
      e.rnd = 4'(tag);
      e.last = (tag == 10);
      sb.push_back(e);
      mrnd = (tag == 10) ? 1 : tag + 1;
    end else if (s) begin
      mrnd = 1;
    end
    @(posedge clk); #1;
    vpipe = {vpipe[0], v};
    chk("valid_out", 128'(valid_out), 128'(vpipe[1]));
    if (vpipe[1] && sb.size() > 0) begin
      e = sb.pop_front();
      chk("data_out", data_out, e.data);
      chk("round_out", 128'(round_out), 128'(e.rnd));
      chk("last_out", 128'(last_out), 128'(e.last));
    end else begin
      chk("last_out_idle", 128'(last_out), 128'(0));
    end
    $display("[TB] t=%0t start=%0b valid_in=%0b -> valid_out=%0b round_out=%0d last_out=%0b data_out=%h",
             $time, s, v, valid_out, round_out, last_out, data_out);
    start = 1'b0;
    valid_in = 1'b0;
  endtask

  initial begin
    #22;
    chk("rst_valid_out", 128'(valid_out), 128'(0));
    chk("rst_data_out", data_out, 128'(0));
    chk("rst_round_out", 128'(round_out), 128'(0));
    chk("rst_last_out", 128'(last_out), 128'(0));
    reset = 1'b1;
    do_cycle(0, 0, '0, '0, 0, '0);

    // FIPS-197 rounds 1..10 from a start, final round with known ciphertext
    do_cycle(1, 1, FIPS_D1, FIPS_K1, 1, FIPS_O1);
    for (int i = 2; i <= 9; i++) do_cycle(0, 1, rnd128(), rnd128(), 0, '0);
    do_cycle(0, 1, FIN_D, FIN_K, 1, FIN_O);
    repeat (2) do_cycle(0, 0, '0, '0, 0, '0);

    // MixColumns column vector
    do_cycle(1, 1, MC_D, '0, 1, MC_O);
    repeat (2) do_cycle(0, 0, '0, '0, 0, '0);

    // Back-to-back beats with a bubble
    do_cycle(1, 1, rnd128(), rnd128(), 0, '0);
    do_cycle(0, 1, rnd128(), rnd128(), 0, '0);
    do_cycle(0, 0, '0, '0, 0, '0);
    do_cycle(0, 1, rnd128(), rnd128(), 0, '0);
    repeat (2) do_cycle(0, 0, '0, '0, 0, '0);

    // Counter wrap: 11 beats after a lone start
    do_cycle(1, 0, '0, '0, 0, '0);
    for (int i = 1; i <= 11; i++) do_cycle(0, 1, rnd128(), rnd128(), 0, '0);
    repeat (2) do_cycle(0, 0, '0, '0, 0, '0);

    // Asynchronous reset with beats in flight
    do_cycle(1, 1, rnd128(), rnd128(), 0, '0);
    do_cycle(0, 1, rnd128(), rnd128(), 0, '0);
    reset = 1'b0; start = 1'b0; valid_in = 1'b0;
    #1;
    chk("rstmid_valid_out", 128'(valid_out), 128'(0));
    chk("rstmid_data_out", data_out, 128'(0));
    chk("rstmid_round_out", 128'(round_out), 128'(0));
    chk("rstmid_last_out", 128'(last_out), 128'(0));
    sb.delete();
    vpipe = 2'b00;
    mrnd = 1;
    @(posedge clk); #1;
    chk("rstmid_hold_valid_out", 128'(valid_out), 128'(0));
    reset = 1'b1;
    repeat (3) do_cycle(0, 0, '0, '0, 0, '0);

`ifdef AES_ROUND_TAIL_ERR_EN
    chk("err_after_reset", 128'(round_err), 128'(0));
    do_cycle(1, 1, rnd128(), rnd128(), 0, '0);
    do_cycle(1, 0, '0, '0, 0, '0);
    chk("err_set", 128'(round_err), 128'(1));
    repeat (2) do_cycle(0, 0, '0, '0, 0, '0);
    chk("err_sticky", 128'(round_err), 128'(1));
    do_cycle(1, 0, '0, '0, 0, '0);
    chk("err_cleared", 128'(round_err), 128'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
